uart_rx_core: RTL and testbench

Oversampling UART receiver: deserialises an asynchronous 8N1-style serial line into parallel words and flags each good frame with a one-cycle ready pulse. It sits behind the board RX pin, is clocked directly by the oversampling clock (OVERSAMPLING clock cycles per bit), and feeds a host-side consumer or FIFO. No parity and no flow control; the framing check is on the stop bit only.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx_core.sv | 135 +++++++++++++
 tb/tb_uart_rx_core.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default frame geometry,
// reused by the companion transmitter.
package uart_pkg;

    localparam int UART_OVERSAMPLING = 8;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a
// configurable reset level so an idle-high line does not glitch at reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_in,
    input  logic nrst_in,
    input  logic d_in,
    output logic q_out
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign q_out = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: finds the start edge, samples each bit at its
// centre and publishes the word with a one-cycle ready pulse on a good stop bit.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int OVERSAMPLING = UART_OVERSAMPLING,  // even, >= 4
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk_in,
    input  logic                 nrst_in,
    input  logic                 rx_serial_in,
    output logic                 data_rdy_out,
    output logic [DATA_BITS-1:0] rx_data_out
);

    localparam int CNT_W = $clog2(OVERSAMPLING);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLING / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLING - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    logic rxs;

    uart_rx_state_t        state_q, state_d;
    logic                  rxs_prev_q, rxs_prev_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  rdy_q, rdy_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_in  (clk_in),
        .nrst_in (nrst_in),
        .d_in    (rx_serial_in),
        .q_out   (rxs)
    );

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state_q    <= IDLE;
            rxs_prev_q <= 1'b1;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rxs_prev_q <= rxs_prev_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            rdy_q      <= rdy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rxs_prev_d = rxs;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        rdy_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // Only a real 1->0 transition starts a frame, so a line stuck
                // low after a framing error stays ignored.
                if (rxs_prev_q && !rxs) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == HALF_LAST) begin
                    if (!rxs) begin
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        state_d   = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    for (int i = 0; i < DATA_BITS; i++) begin
                        if (bit_idx_q == IDX_W'(i)) begin
                            shift_d[i] = rxs;
                        end
                    end
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    // A low stop bit is a framing error: the word is dropped.
                    if (rxs) begin
                        data_d = shift_q;
                        rdy_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_rdy_out = rdy_q;
    assign rx_data_out  = data_q;

endmodule : uart_rx_core

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core with default geometry: 8 ticks per bit,
// 8 data bits, every bit held exactly 8 clock cycles.
module tb_uart_rx_core;

    localparam int OS = 8;

    logic       clk_in;
    logic       nrst_in;
    logic       rx_serial_in;
    logic       data_rdy_out;
    logic [7:0] rx_data_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] got_q[$];
    int         got_cyc[$];

    uart_rx_core #(
        .OVERSAMPLING (8),
        .DATA_BITS    (8)
    ) dut (
        .clk_in       (clk_in),
        .nrst_in      (nrst_in),
        .rx_serial_in (rx_serial_in),
        .data_rdy_out (data_rdy_out),
        .rx_data_out  (rx_data_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Every sampled high cycle of data_rdy_out is logged, so a stretched
    // pulse shows up as an extra entry.
    always @(negedge clk_in) begin
        if (data_rdy_out) begin
            got_q.push_back(rx_data_out);
            got_cyc.push_back(cyc);
            $display("rx word 0x%02h at cycle %0d", rx_data_out, cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx_serial_in = 1'b0;
        wait_cycles(OS);
        for (int i = 0; i < 8; i++) begin
            rx_serial_in = d[i];
            wait_cycles(OS);
        end
        rx_serial_in = stop_bit;
        wait_cycles(OS);
        rx_serial_in = 1'b1;
        $display("sent frame 0x%02h stop %0b", d, stop_bit);
    endtask

    task automatic clear_log();
        got_q.delete();
        got_cyc.delete();
    endtask

    logic [7:0] sweep [16] = '{8'h10, 8'h01, 8'h91, 8'hAB, 8'hBA, 8'hAF, 8'hFA, 8'h22,
                               8'h11, 8'h99, 8'h11, 8'h00, 8'h13, 8'hFF, 8'h25, 8'h23};

    initial begin
        int c0;
        int lat;
        logic lat_ok;

        // Reset with line idle.
        rx_serial_in = 1'b1;
        nrst_in      = 1'b0;
        wait_cycles(3);
        check("reset_rdy", {31'd0, data_rdy_out}, 32'd0);
        check("reset_data", {24'd0, rx_data_out}, 32'd0);
        nrst_in = 1'b1;
        wait_cycles(200);
        check("idle_no_pulse", got_q.size(), 32'd0);

        // Single frame and latency from start edge.
        clear_log();
        c0 = cyc;
        send_frame(8'hA5, 1'b1);
        wait_cycles(2 * OS);
        check("single_count", got_q.size(), 32'd1);
        if (got_q.size() > 0) begin
            check("single_value", {24'd0, got_q[0]}, 32'h0000_00A5);
            lat    = got_cyc[0] - c0;
            lat_ok = (lat >= 78) && (lat <= 80);
            check("single_latency_in_79pm1", {31'd0, lat_ok}, 32'd1);
        end
        check("single_hold", {24'd0, rx_data_out}, 32'h0000_00A5);

        // Pattern sweep with 2 idle bit-times between frames.
        clear_log();
        for (int i = 0; i < 16; i++) begin
            send_frame(sweep[i], 1'b1);
            wait_cycles(2 * OS);
        end
        check("sweep_count", got_q.size(), 32'd16);
        if (got_q.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check($sformatf("sweep_%0d", i), {24'd0, got_q[i]}, {24'd0, sweep[i]});
            end
        end

        // Back-to-back frames, no idle gap.
        clear_log();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_cycles(2 * OS);
        check("b2b_count", got_q.size(), 32'd2);
        if (got_q.size() == 2) begin
            check("b2b_first", {24'd0, got_q[0]}, 32'h0000_0000);
            check("b2b_second", {24'd0, got_q[1]}, 32'h0000_00FF);
        end

        // Short low glitch must be rejected at mid start bit.
        clear_log();
        rx_serial_in = 1'b0;
        wait_cycles(3);
        rx_serial_in = 1'b1;
        wait_cycles(100);
        check("glitch_no_pulse", got_q.size(), 32'd0);

        // Framing error keeps previous word; next good frame still lands.
        send_frame(8'h55, 1'b0);
        wait_cycles(3 * OS);
        check("frame_err_no_pulse", got_q.size(), 32'd0);
        check("frame_err_hold", {24'd0, rx_data_out}, 32'h0000_00FF);
        send_frame(8'h3C, 1'b1);
        wait_cycles(2 * OS);
        check("after_err_count", got_q.size(), 32'd1);
        if (got_q.size() == 1) begin
            check("after_err_value", {24'd0, got_q[0]}, 32'h0000_003C);
        end

        // Asynchronous reset in the middle of the data bits.
        clear_log();
        rx_serial_in = 1'b0;
        wait_cycles(OS);
        rx_serial_in = 1'b1;
        wait_cycles(3 * OS);
        nrst_in = 1'b0;
        #1;
        check("async_rst_rdy", {31'd0, data_rdy_out}, 32'd0);
        check("async_rst_data", {24'd0, rx_data_out}, 32'd0);
        wait_cycles(2);
        nrst_in = 1'b1;
        wait_cycles(100);
        check("async_rst_no_pulse", got_q.size(), 32'd0);
        send_frame(8'h5A, 1'b1);
        wait_cycles(2 * OS);
        check("post_rst_count", got_q.size(), 32'd1);
        if (got_q.size() == 1) begin
            check("post_rst_value", {24'd0, got_q[0]}, 32'h0000_005A);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_core
